// File: rtl/buck_interleave_pwm.sv
// N-phase interleaved synchronous-buck gate generator: one master period counter,
// per-phase offsets, dead time, minimum on-time and a sticky over-current trip.
module buck_interleave_pwm #(
  parameter int NUM_PHASE = 2,
  parameter int CNT_W     = 16,
  parameter int DEAD_TIME = 10,
  parameter int MIN_ON    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       period,
  input  logic [CNT_W-1:0]       duty,
  input  logic                   cfg_load,
  input  logic                   over_current,
  input  logic                   fault_clear,
  output logic [2*NUM_PHASE-1:0] mosfet_out,
  output logic                   phase_sync,
  output logic                   cfg_err,
  output logic                   fault,
  output logic                   busy
);
  localparam int SHIFT = $clog2(NUM_PHASE);
  localparam int MUL_W = CNT_W + ((SHIFT > 0) ? SHIFT : 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DT       = CNT_W'(DEAD_TIME);
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2 * DEAD_TIME + 2);
  localparam logic [CNT_W-1:0] CLAMP    = CNT_W'(2 * DEAD_TIME + 1);
  localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic                   enable_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]       shadow_period_q, shadow_period_d;
  logic [CNT_W-1:0]       shadow_duty_q, shadow_duty_d;
  logic [CNT_W-1:0]       act_period_q, act_period_d;
  logic [CNT_W-1:0]       act_duty_q, act_duty_d;
  logic [2*NUM_PHASE-1:0] mosfet_q, mosfet_d;
  logic                   sync_q, sync_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   fault_q, fault_d;

  logic                   load_ok, load_bad, en_rise, start_ok, wrap, copy_act;
  logic [CNT_W-1:0]       src_period, src_duty, src_duty_eff, duty_max;
  logic [2*NUM_PHASE-1:0] gates;

  assign load_ok  = cfg_load && !over_current && (period >= MIN_PER);
  assign load_bad = cfg_load && !over_current && (period < MIN_PER);
  // fault_q masks enable edges so a restart always needs a fresh rise
  assign en_rise  = enable && !enable_q && !fault_q && !over_current && (state_q == S_IDLE);
  assign start_ok = en_rise && (load_ok || (shadow_period_q != '0));
  assign wrap     = (state_q == S_RUN) && (cnt_q == act_period_q - ONE);

  always_comb begin
    src_period = shadow_period_q;
    src_duty   = shadow_duty_q;
    if (en_rise && load_ok) begin
      src_period = period;
      src_duty   = duty;
    end
  end

  assign duty_max     = src_period - CLAMP;
  assign src_duty_eff = (src_duty < MIN_ON_C) ? '0 :
                        ((src_duty > duty_max) ? duty_max : src_duty);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASE; gi++) begin : g_phase
      logic [MUL_W-1:0] prod;
      logic [CNT_W-1:0] off_q, off_d, loc;

      assign prod  = MUL_W'(gi) * MUL_W'(src_period);
      assign off_d = copy_act ? CNT_W'(prod >> SHIFT) : off_q;
      // local count without a divider: wrap back into range by adding period
      assign loc = (cnt_q >= off_q) ? (cnt_q - off_q) : (cnt_q - off_q + act_period_q);
      assign gates[2*gi+1] = (act_duty_q != '0) && (loc >= DT) && (loc < DT + act_duty_q);
      assign gates[2*gi]   = (act_duty_q == '0) || (loc >= DT + DT + act_duty_q);

      always_ff @(posedge clk) begin
        if (!rst_n) off_q <= '0;
        else        off_q <= off_d;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      enable_q        <= 1'b0;
      cnt_q           <= '0;
      pre_cnt_q       <= '0;
      shadow_period_q <= '0;
      shadow_duty_q   <= '0;
      act_period_q    <= '0;
      act_duty_q      <= '0;
      mosfet_q        <= '0;
      sync_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      enable_q        <= enable;
      cnt_q           <= cnt_d;
      pre_cnt_q       <= pre_cnt_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      act_period_q    <= act_period_d;
      act_duty_q      <= act_duty_d;
      mosfet_q        <= mosfet_d;
      sync_q          <= sync_d;
      cfg_err_q       <= cfg_err_d;
      fault_q         <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (over_current || !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = (DEAD_TIME > 1) ? S_PRE : S_RUN;
        S_PRE:   if (pre_cnt_q >= DT - ONE) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d           = cnt_q;
    pre_cnt_d       = pre_cnt_q;
    shadow_period_d = shadow_period_q;
    shadow_duty_d   = shadow_duty_q;
    act_period_d    = act_period_q;
    act_duty_d      = act_duty_q;
    copy_act        = 1'b0;
    fault_d         = fault_q;
    cfg_err_d       = load_bad || (en_rise && !start_ok);

    if (over_current)     fault_d = 1'b1;
    else if (fault_clear) fault_d = 1'b0;

    if (load_ok) begin
      shadow_period_d = period;
      shadow_duty_d   = duty;
    end

    if (state_d == S_IDLE) begin
      if (!over_current && !fault_q) cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      copy_act  = 1'b1;
      cnt_d     = '0;
      pre_cnt_d = ONE;
    end else if (state_q == S_PRE) begin
      pre_cnt_d = pre_cnt_q + ONE;
    end else begin
      cnt_d    = wrap ? '0 : cnt_q + ONE;
      copy_act = wrap;
    end

    if (copy_act) begin
      act_period_d = src_period;
      act_duty_d   = src_duty_eff;
    end
  end

  always_comb begin
    mosfet_d = '0;
    sync_d   = 1'b0;
    if (state_q == S_RUN && state_d == S_RUN) begin
      mosfet_d = gates;
      sync_d   = (cnt_q == '0);
    end
  end

  assign mosfet_out = mosfet_q;
  assign phase_sync = sync_q;
  assign cfg_err    = cfg_err_q;
  assign fault      = fault_q;
  assign busy       = (state_q != S_IDLE);
endmodule
